// File: rtl/traffic_pkg.sv
// Shared lamp encodings, fault codes and FSM state type for the
// traffic conflict monitor and its per-direction dwell trackers.
package traffic_pkg;

   // Lamp codes are one-hot {R,Y,G}
   localparam logic [2:0] RED      = 3'b100;
   localparam logic [2:0] YELLOW   = 3'b010;
   localparam logic [2:0] GREEN    = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   localparam logic [2:0] FC_NONE     = 3'd0;
   localparam logic [2:0] FC_ENCODING = 3'd1;
   localparam logic [2:0] FC_CONFLICT = 3'd2;
   localparam logic [2:0] FC_SEQUENCE = 3'd3;
   localparam logic [2:0] FC_SHORT    = 3'd4;
   localparam logic [2:0] FC_STALL    = 3'd5;

   typedef enum logic {
      ST_MONITOR = 1'b0,
      ST_FAULT   = 1'b1
   } state_e;

   function automatic logic is_one_hot(input logic [2:0] code);
      return (code == RED) || (code == YELLOW) || (code == GREEN);
   endfunction

endpackage

// File: rtl/light_dwell_tracker.sv
// Per-direction history: remembers the previous lamp sample and how many
// consecutive samples the current colour has been held, and flags illegal
// transitions, colours left too early, and colours held too long.
module light_dwell_tracker
   import traffic_pkg::*;
#(
   parameter int MIN_GREEN  = 16,
   parameter int MIN_YELLOW = 16,
   parameter int MAX_PHASE  = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] cur,
   input  logic       first,
   output logic       bad_seq,
   output logic       short_phase,
   output logic       stall
);

   // Wide enough to hold the saturation value MAX_PHASE+1
   localparam int DW = $clog2(MAX_PHASE + 2);

   logic [2:0]    prev_q, prev_d;
   logic [DW-1:0] dwell_q, dwell_d;

   // Dwell of the current sample and the transition checks against prev
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
      prev_d      = cur;
      dwell_d     = dwell_q;
      bad_seq     = 1'b0;
      short_phase = 1'b0;

      if (first || (cur != prev_q)) begin
         dwell_d = DW'(1);
      end else if (dwell_q <= DW'(MAX_PHASE)) begin
         dwell_d = dwell_q + 1'b1;
      end

      // dwell_q is the length of the run that prev belongs to
      if (!first && (cur != prev_q)) begin
         case ({prev_q, cur})
            {GREEN, YELLOW}: short_phase = (dwell_q < DW'(MIN_GREEN));
            {YELLOW, RED}:   short_phase = (dwell_q < DW'(MIN_YELLOW));
            {RED, GREEN}:    short_phase = 1'b0;
            default:         bad_seq     = 1'b1;
         endcase
      end

      stall = (dwell_d > DW'(MAX_PHASE));
   end

   // History registers
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
      if (reset) begin
         prev_q  <= RED;
         dwell_q <= DW'(1);
      end else begin
         prev_q  <= prev_d;
         dwell_q <= dwell_d;
      end
   end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the traffic light controller and the lamp drivers.
// Forwards lamp codes two cycles late while they are legal; on the first
// violation it latches a fault code and flashes red on both directions
// until the operator clears it with a legal, non-conflicting sample present.
module traffic_conflict_monitor
   import traffic_pkg::*;
#(
   parameter int MIN_GREEN  = 16,
   parameter int MIN_YELLOW = 16,
   parameter int MAX_PHASE  = 64,
   parameter int FLASH_HALF = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] ns_in,
   input  logic [2:0] ew_in,
   input  logic       fault_clear,
   output logic [2:0] ns_out,
   output logic [2:0] ew_out,
   output logic       fault,
   output logic [2:0] fault_code
);

   localparam int FW = $clog2(2 * FLASH_HALF);

   state_e        state_q, state_d;
   logic [2:0]    cur_ns_q, cur_ns_d, cur_ew_q, cur_ew_d;
   logic [2:0]    ns_out_q, ns_out_d, ew_out_q, ew_out_d;
   logic [2:0]    code_q, code_d;
   logic          first_q, first_d;
   logic [FW-1:0] flash_q, flash_d;

   logic       enc_bad, conflict;
   logic       ns_bad_seq, ns_short, ns_stall;
   logic       ew_bad_seq, ew_short, ew_stall;
   logic [2:0] hit_code;

   light_dwell_tracker #(
      .MIN_GREEN (MIN_GREEN),
      .MIN_YELLOW(MIN_YELLOW),
      .MAX_PHASE (MAX_PHASE)
   ) u_ns_tracker (
      .clk        (clk),
      .reset      (reset),
      .cur        (cur_ns_q),
      .first      (first_q),
      .bad_seq    (ns_bad_seq),
      .short_phase(ns_short),
      .stall      (ns_stall)
   );

   light_dwell_tracker #(
      .MIN_GREEN (MIN_GREEN),
      .MIN_YELLOW(MIN_YELLOW),
      .MAX_PHASE (MAX_PHASE)
   ) u_ew_tracker (
      .clk        (clk),
      .reset      (reset),
      .cur        (cur_ew_q),
      .first      (first_q),
      .bad_seq    (ew_bad_seq),
      .short_phase(ew_short),
      .stall      (ew_stall)
   );

   // Sample-level checks, lowest fault code wins
   always_comb begin
      enc_bad  = !is_one_hot(cur_ns_q) || !is_one_hot(cur_ew_q);
      conflict = (cur_ns_q != RED) && (cur_ew_q != RED);
      hit_code = FC_NONE;
      if (enc_bad) begin
         hit_code = FC_ENCODING;
      end else if (conflict) begin
         hit_code = FC_CONFLICT;
      end else if (ns_bad_seq || ew_bad_seq) begin
         hit_code = FC_SEQUENCE;
      end else if (ns_short || ew_short) begin
         hit_code = FC_SHORT;
      end else if (ns_stall || ew_stall) begin
         hit_code = FC_STALL;
      end
   end

   // Next state, fault latch, flasher and lamp outputs
   always_comb begin
      cur_ns_d = ns_in;
      cur_ew_d = ew_in;
      state_d  = state_q;
      code_d   = code_q;
      first_d  = first_q;
      flash_d  = flash_q;
      ns_out_d = ns_out_q;
      ew_out_d = ew_out_q;

      case (state_q)
         ST_MONITOR: begin
            first_d = 1'b0;
            if (hit_code != FC_NONE) begin
               state_d  = ST_FAULT;
               code_d   = hit_code;
               flash_d  = '0;
               ns_out_d = RED;
               ew_out_d = RED;
            end else begin
               ns_out_d = cur_ns_q;
               ew_out_d = cur_ew_q;
            end
         end
         ST_FAULT: begin
            // Only encoding and conflict gate recovery; history restarts via first_d
            if (fault_clear && !enc_bad && !conflict) begin
               state_d  = ST_MONITOR;
               code_d   = FC_NONE;
               first_d  = 1'b1;
               ns_out_d = cur_ns_q;
               ew_out_d = cur_ew_q;
            end else begin
               flash_d  = (flash_q == FW'(2 * FLASH_HALF - 1)) ? '0 : flash_q + 1'b1;
               ns_out_d = (flash_d < FW'(FLASH_HALF)) ? RED : LAMP_OFF;
               ew_out_d = (flash_d < FW'(FLASH_HALF)) ? RED : LAMP_OFF;
            end
         end
         default: state_d = ST_MONITOR;
      endcase
   end

   // Pipeline, FSM and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_MONITOR;
         cur_ns_q <= RED;
         cur_ew_q <= RED;
         ns_out_q <= RED;
         ew_out_q <= RED;
         code_q   <= FC_NONE;
         first_q  <= 1'b1;
         flash_q  <= '0;
      end else begin
         state_q  <= state_d;
         cur_ns_q <= cur_ns_d;
         cur_ew_q <= cur_ew_d;
         ns_out_q <= ns_out_d;
         ew_out_q <= ew_out_d;
         code_q   <= code_d;
         first_q  <= first_d;
         flash_q  <= flash_d;
      end
   end

   assign ns_out     = ns_out_q;
   assign ew_out     = ew_out_q;
   assign fault      = (state_q == ST_FAULT);
   assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench for traffic_conflict_monitor: the driver feeds one lamp
// sample per cycle, a sample-stream reference model predicts the lamp/fault
// outputs after the next edge and queues them, and a monitor compares.
module tb_traffic_conflict_monitor;

   localparam logic [2:0] L_RED = 3'b100;
   localparam logic [2:0] L_YEL = 3'b010;
   localparam logic [2:0] L_GRN = 3'b001;
   localparam logic [2:0] L_OFF = 3'b000;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] ns_in, ew_in;
   logic       fault_clear;
   logic [2:0] ns_out, ew_out, fault_code;
   logic       fault;

   traffic_conflict_monitor dut (
      .clk        (clk),
      .reset      (reset),
      .ns_in      (ns_in),
      .ew_in      (ew_in),
      .fault_clear(fault_clear),
      .ns_out     (ns_out),
      .ew_out     (ew_out),
      .fault      (fault),
      .fault_code (fault_code)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] ns;
      logic [2:0] ew;
      logic       flt;
      logic [2:0] code;
   } obs_t;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cycle    = 0;

   // Reference model: the sample stream as seen by the checker
   logic [2:0] m_cur[2];
   logic [2:0] m_prev[2];
   int         m_run[2];
   bit         m_first, m_fault;
   int         m_code, m_flash;
   obs_t       m_out;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %b, expected %b", name, cycle, act[9:0], req[9:0]);
      end
   endtask

   function automatic bit lamp_ok(input logic [2:0] c);
      return (c == L_RED) || (c == L_YEL) || (c == L_GRN);
   endfunction

   function automatic bit step_ok(input logic [2:0] p, input logic [2:0] c);
      return (p == L_GRN && c == L_YEL) || (p == L_YEL && c == L_RED) || (p == L_RED && c == L_GRN);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_cur[d]  = L_RED;
         m_prev[d] = L_RED;
         m_run[d]  = 1;
      end
      m_first = 1'b1;
      m_fault = 1'b0;
      m_code  = 0;
      m_flash = 0;
      m_out   = {L_RED, L_RED, 1'b0, 3'd0};
   endtask

   // Judge the sample now in the checker, then accept the new input sample
   task automatic model_step(input logic [2:0] ns, input logic [2:0] ew, input bit clr);
      int rn[2];
      int code;
      for (int d = 0; d < 2; d++)
         rn[d] = (m_first || m_cur[d] != m_prev[d]) ? 1 : ((m_run[d] + 1 > 65) ? 65 : m_run[d] + 1);
      if (!m_fault) begin
         code = 0;
         if (!lamp_ok(m_cur[0]) || !lamp_ok(m_cur[1])) code = 1;
         else if (m_cur[0] != L_RED && m_cur[1] != L_RED) code = 2;
         else begin
            if (!m_first)
               for (int d = 0; d < 2; d++)
                  if (m_cur[d] != m_prev[d] && !step_ok(m_prev[d], m_cur[d])) code = 3;
            if (code == 0 && !m_first)
               for (int d = 0; d < 2; d++)
                  if ((m_prev[d] == L_GRN && m_cur[d] == L_YEL && m_run[d] < 16) ||
                      (m_prev[d] == L_YEL && m_cur[d] == L_RED && m_run[d] < 16)) code = 4;
            if (code == 0)
               for (int d = 0; d < 2; d++)
                  if (rn[d] > 64) code = 5;
         end
         m_first = 1'b0;
         if (code != 0) begin
            m_fault = 1'b1;
            m_code  = code;
            m_flash = 0;
            m_out   = {L_RED, L_RED, 1'b1, 3'(code)};
         end else begin
            m_out = {m_cur[0], m_cur[1], 1'b0, 3'd0};
         end
      end else if (clr && lamp_ok(m_cur[0]) && lamp_ok(m_cur[1]) &&
                   !(m_cur[0] != L_RED && m_cur[1] != L_RED)) begin
         m_fault = 1'b0;
         m_code  = 0;
         m_first = 1'b1;
         m_out   = {m_cur[0], m_cur[1], 1'b0, 3'd0};
      end else begin
         m_flash = (m_flash + 1) % 16;
         m_out   = (m_flash < 8) ? {L_RED, L_RED, 1'b1, 3'(m_code)} : {L_OFF, L_OFF, 1'b1, 3'(m_code)};
      end
      for (int d = 0; d < 2; d++) begin
         m_prev[d] = m_cur[d];
         m_run[d]  = rn[d];
      end
      m_cur[0] = ns;
      m_cur[1] = ew;
   endtask

   // Called at a negedge; drives one sample and returns at the next negedge
   task automatic step(input logic [2:0] ns, input logic [2:0] ew, input bit clr);
      ns_in       = ns;
      ew_in       = ew;
      fault_clear = clr;
      model_step(ns, ew, clr);
      exp_q.push_back(m_out);
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1 check("reset_async", {22'd0, ns_out, ew_out, fault, fault_code}, {22'd0, L_RED, L_RED, 1'b0, 3'd0});
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_code(input string name, input logic [2:0] code);
      check(name, {28'd0, fault, fault_code}, {28'd0, 1'b1, code});
   endtask

   // Monitor: one comparison per queued expectation, after each rising edge
   initial begin
      obs_t e;
      forever begin
         @(posedge clk);
         cycle++;
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("scoreboard", {22'd0, ns_out, ew_out, fault, fault_code}, {22'd0, e});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [2:0] pat_ns(input int t);
      return (t < 16) ? L_GRN : (t < 32) ? L_YEL : L_RED;
   endfunction

   function automatic logic [2:0] pat_ew(input int t);
      return (t < 32) ? L_RED : (t < 48) ? L_GRN : L_YEL;
   endfunction

   int         phase, left;
   logic [2:0] rns, rew;

   initial begin
      reset       = 1'b1;
      ns_in       = L_RED;
      ew_in       = L_RED;
      fault_clear = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_state", {22'd0, ns_out, ew_out, fault, fault_code}, {22'd0, L_RED, L_RED, 1'b0, 3'd0});
      reset = 1'b0;

      // Legal controller pattern, three loops
      for (int l = 0; l < 3; l++)
         for (int t = 0; t < 64; t++) step(pat_ns(t), pat_ew(t), 1'b0);
      check("pattern_no_fault", {31'd0, fault}, 32'd0);

      // One-cycle conflict mid-run, then flash and clear
      for (int t = 0; t < 8; t++) step(pat_ns(t), pat_ew(t), 1'b0);
      step(L_GRN, L_GRN, 1'b0);
      repeat (20) step(L_RED, L_RED, 1'b0);
      check_code("conflict_code", 3'd2);
      step(L_RED, L_RED, 1'b1);
      repeat (2) step(L_RED, L_RED, 1'b0);

      // Green left after 10 samples
      repeat (10) step(L_GRN, L_RED, 1'b0);
      step(L_YEL, L_RED, 1'b0);
      repeat (3) step(L_RED, L_RED, 1'b0);
      check_code("short_green_code", 3'd4);
      step(L_RED, L_RED, 1'b1);
      repeat (2) step(L_RED, L_RED, 1'b0);

      // Green straight to red
      repeat (20) step(L_GRN, L_RED, 1'b0);
      repeat (4) step(L_RED, L_RED, 1'b0);
      check_code("bad_sequence_code", 3'd3);
      step(L_RED, L_RED, 1'b1);

      // Frozen inputs: stall once the 65th identical sample is checked
      step(L_GRN, L_RED, 1'b1);
      repeat (69) step(L_GRN, L_RED, 1'b0);
      repeat (2) step(L_RED, L_RED, 1'b0);
      check_code("stall_code", 3'd5);
      step(L_RED, L_RED, 1'b1);
      repeat (2) step(L_RED, L_RED, 1'b0);

      // Bad encoding together with a conflict, then recovery attempts
      step(3'b011, L_GRN, 1'b0);
      repeat (4) step(3'b011, L_GRN, 1'b1);
      check_code("encoding_priority", 3'd1);
      step(L_RED, L_RED, 1'b1);
      check_code("no_clear_on_bad_sample", 3'd1);
      step(L_YEL, L_RED, 1'b1);
      repeat (15) step(L_YEL, L_RED, 1'b0);
      repeat (3) step(L_RED, L_RED, 1'b0);
      check("recovered_no_seq_fault", {28'd0, fault, fault_code}, 32'd0);

      // Randomized controller with short phases, corruption and clears
      phase = 0;
      left  = $urandom_range(13, 22);
      for (int c = 0; c < 1500; c++) begin
         case (phase)
            0:       begin rns = L_GRN; rew = L_RED; end
            1:       begin rns = L_YEL; rew = L_RED; end
            3:       begin rns = L_RED; rew = L_GRN; end
            4:       begin rns = L_RED; rew = L_YEL; end
            default: begin rns = L_RED; rew = L_RED; end
         endcase
         if ($urandom_range(0, 39) == 0) rns = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 39) == 0) rew = 3'($urandom_range(0, 7));
         step(rns, rew, $urandom_range(0, 7) == 0);
         left--;
         if (left == 0) begin
            phase = (phase + 1) % 6;
            left  = (phase == 2 || phase == 5) ? $urandom_range(1, 12) : $urandom_range(13, 22);
         end
      end

      // Async reset during the flash off-phase
      do_reset();
      repeat (2) step(L_RED, L_RED, 1'b0);
      step(L_GRN, L_GRN, 1'b0);
      for (int i = 0; i < 40 && !(m_fault && m_flash >= 10); i++) step(L_RED, L_RED, 1'b0);
      check("flash_off_before_reset", {26'd0, ns_out, ew_out}, {26'd0, L_OFF, L_OFF});
      do_reset();
      repeat (5) step(L_GRN, L_RED, 1'b0);
      step(L_GRN, L_RED, 1'b0);

      repeat (3) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
